// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline control unit: stall-vector encodings,
// memory-stage exception type codes, watchdog counter width and the
// controller FSM state encoding.
// Used by pipe_ctrl and stall_watchdog via import pipe_ctrl_pkg::*.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   // Stall vector encodings, bit0 = pc ... bit5 = wb, 1 means Stop
   localparam logic [5:0] STALL_NONE     = 6'b000000;
   localparam logic [5:0] STALL_FROM_ID  = 6'b000111;
   localparam logic [5:0] STALL_FROM_EX  = 6'b001111;
   localparam logic [5:0] STALL_FROM_MEM = 6'b011111;

   // Exception type codes delivered by the memory stage
   localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
   localparam logic [31:0] EXC_INT     = 32'h0000_0001;
   localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
   localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
   localparam logic [31:0] EXC_OV      = 32'h0000_000c;
   localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
   localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

   // Width of the stall watchdog counter
   localparam int WDOG_W = 16;

   // Controller states: normal operation, and the single cycle after a flush
   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_REDIRECT = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// -----------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive stalled cycles and raises a sticky flag once the count
// reaches STALL_TIMEOUT, catching requesters that never release a stall.
// Ports:
//   clk           in  1  clock, rising edge
//   rst           in  1  synchronous active-low reset
//   stall_active  in  1  stall vector is non-zero this cycle
//   flush         in  1  pipeline flush this cycle (clears the count)
//   stall_timeout out 1  sticky timeout flag, forced low while rst=0
// -----------------------------------------------------------------------------
module stall_watchdog
   import pipe_ctrl_pkg::*;
#(
   parameter int STALL_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_active,
   input  logic flush,
   output logic stall_timeout
);

   localparam logic [WDOG_W-1:0] LIMIT    = WDOG_W'(STALL_TIMEOUT);
   localparam logic [WDOG_W-1:0] CNT_MAX  = {WDOG_W{1'b1}};

   logic [WDOG_W-1:0] count;
   logic [WDOG_W-1:0] count_inc;
   logic              timeout_flag;

   // Saturating increment so a very long stall never wraps back below LIMIT
   always_comb begin
      count_inc = count;
      if (count != CNT_MAX) begin
         count_inc = count + 1'b1;
      end
   end

   // The flag is set on the edge where the incremented count reaches LIMIT,
   // so it is visible right after the STALL_TIMEOUT-th stalled edge
   always_ff @(posedge clk) begin
      if (!rst) begin
         count        <= '0;
         timeout_flag <= 1'b0;
      end else if (stall_active && !flush) begin
         count <= count_inc;
         if (count_inc >= LIMIT) begin
            timeout_flag <= 1'b1;
         end
      end else begin
         count <= '0;
      end
   end

   assign stall_timeout = rst & timeout_flag;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit for the five-stage core. Merges per-stage stall
// requests into the 6-bit stall vector and turns memory-stage exceptions into
// a one-cycle flush with a redirect PC. A RUN/REDIRECT FSM drops the exception
// candidate in the cycle after a flush (mem holds a bubble then).
// Optional feature macro: PIPE_CTRL_PERF_EN adds perf_stall_cycles and
// perf_flush_count outputs.
// Ports:
//   clk, rst (sync active-low)
//   stallreq_from_if/id/ex/mem   stage stall requests
//   excepttype_i [31:0]          mem-stage exception type, 0 = none
//   cp0_epc_i    [31:0]          forwarded EPC, target for eret
//   stall        [5:0]           per-stage stop vector
//   flush                        squash all pipeline registers
//   new_pc       [31:0]          redirect target, valid while flush=1
//   stall_timeout                sticky watchdog flag
//   perf_stall_cycles [31:0]     (PIPE_CTRL_PERF_EN) cycles with stall[0]=1
//   perf_flush_count  [15:0]     (PIPE_CTRL_PERF_EN) number of flushes
// -----------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] HANDLER_ADDR  = 32'h0000_0020,
   parameter int          STALL_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_if,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0] perf_stall_cycles,
   output logic [15:0] perf_flush_count,
`endif
   output logic        stall_timeout
);

   ctrl_state_e state;
   ctrl_state_e state_next;
   logic        flush_raw;
   logic [5:0]  stall_raw;
   logic [31:0] target;
   logic [31:0] new_pc_q;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next state and outputs. Flush overrides every stall request; while rst
   // is low all outputs are forced to their reset values.
   always_comb begin
      state_next = state;
      flush_raw  = 1'b0;
      stall_raw  = STALL_NONE;
      target     = HANDLER_ADDR;

      if (excepttype_i == EXC_ERET) begin
         target = cp0_epc_i;
      end

      case (state)
         ST_RUN: begin
            if (excepttype_i != EXC_NONE) begin
               flush_raw  = 1'b1;
               state_next = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            state_next = ST_RUN;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase

      if (!flush_raw) begin
         if (stallreq_from_mem) begin
            stall_raw = STALL_FROM_MEM;
         end else if (stallreq_from_ex) begin
            stall_raw = STALL_FROM_EX;
         end else if (stallreq_from_id || stallreq_from_if) begin
            stall_raw = STALL_FROM_ID;
         end
      end

      stall  = rst ? stall_raw : STALL_NONE;
      flush  = rst & flush_raw;
      new_pc = 32'h0;
      if (rst) begin
         new_pc = flush_raw ? target : new_pc_q;
      end
   end

   // Captured redirect target, held through REDIRECT and afterwards
   always_ff @(posedge clk) begin
      if (!rst) begin
         new_pc_q <= 32'h0;
      end else if (flush_raw) begin
         new_pc_q <= target;
      end
   end

   stall_watchdog #(
      .STALL_TIMEOUT (STALL_TIMEOUT)
   ) u_watchdog (
      .clk           (clk),
      .rst           (rst),
      .stall_active  (stall_raw != STALL_NONE),
      .flush         (flush_raw),
      .stall_timeout (stall_timeout)
   );

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [15:0] flush_count_q;

   // Free-running event counters, wrapping naturally
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cycles_q <= 32'h0;
         flush_count_q  <= 16'h0;
      end else begin
         if (stall_raw[0]) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (flush_raw) begin
            flush_count_q <= flush_count_q + 16'd1;
         end
      end
   end

   assign perf_stall_cycles = rst ? stall_cycles_q : 32'h0;
   assign perf_flush_count  = rst ? flush_count_q  : 16'h0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage core. It merges per-stage stall requests into the 6-bit `stall` vector, and turns memory-stage exception types into a one-cycle `flush` plus the redirect PC. It is the producer of the `stall`/`flush` signals consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. A two-state FSM guards the cycle after a flush, and a stall watchdog catches deadlocked requesters.

## Interface
Parameters:
- `HANDLER_ADDR`, 32'h0000_0020, exception vector for all non-eret exceptions.
- `STALL_TIMEOUT`, 64, consecutive stalled cycles before `stall_timeout` sets (range 2..65535).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `stallreq_from_if`  in  1  fetch stall request.
- `stallreq_from_id`  in  1  decode stall request (load-use).
- `stallreq_from_ex`  in  1  execute stall request (multi-cycle div/madd).
- `stallreq_from_mem`  in  1  memory stall request.
- `excepttype_i`  in  32  exception type from mem stage; 0 means none.
- `cp0_epc_i`  in  32  current EPC, already forwarded.
- `stall`  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 means Stop.
- `flush`  out  1  squash all pipeline registers this cycle.
- `new_pc`  out  32  redirect target, valid while `flush`=1.
- `stall_timeout`  out  1  sticky watchdog flag.

## Operation
- FSM states: RUN, REDIRECT. Reset state is RUN.
- In RUN, if `excepttype_i` is non-zero:
  - `flush`=1 and `stall`=0 combinationally in the same cycle. Flush overrides every stall request.
  - `new_pc` = `cp0_epc_i` when type is 32'h0000_000e (eret); otherwise `HANDLER_ADDR`. This covers types 01 interrupt, 08 syscall, 0a invalid, 0c overflow and 0d trap, plus any other non-zero code.
  - Next state is REDIRECT.
  - `new_pc` is captured into a register.
- In REDIRECT:
  - `excepttype_i` is ignored, because mem holds a bubble. `flush`=0.
  - `new_pc` keeps driving the captured value.
  - Stall requests are honoured normally.
  - Next state is RUN unconditionally.
- Stall priority, applied when there is no flush; the highest requester wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000111
  - none → 6'b000000
- Watchdog: a saturating counter increments each cycle `stall`≠0 and clears on any cycle with `stall`=0 or `flush`=1. When the counter reaches `STALL_TIMEOUT`, `stall_timeout` sets and stays set until reset.
- Counter width: 16 bits. It saturates at 16'hFFFF with no wrap.

## Timing
- `stall`, `flush` and `new_pc` have zero-cycle latency from their inputs. The FSM and registered `new_pc` update on the clock edge.
- A flush lasts exactly one cycle. Back-to-back exceptions are impossible: the second candidate falls in REDIRECT and is dropped.
- The redirected instruction reaches mem no earlier than 3 cycles later.
- Exception and `stallreq_from_mem` in the same cycle: flush wins. The stall requester re-asserts next cycle if still needed.
- Reset (`rst`=0 at an edge): on the following cycle the state is RUN, `stall`=0, `flush`=0, `new_pc`=0, `stall_timeout`=0, watchdog counter=0, and perf counters=0.
  - While `rst`=0, outputs are forced to these values combinationally, including mid-stall and mid-REDIRECT.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: adds two outputs.
  - `perf_stall_cycles` (32): increments each cycle with `stall[0]`=1.
  - `perf_flush_count` (16): increments per flush.
  - Both wrap modulo 2^width and clear on reset.
- `PIPE_CTRL_PERF_EN` undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Shared package/def header holds:
  - the stall-vector constants (`STALL_NONE`, `STALL_FROM_ID`, `STALL_FROM_EX`, `STALL_FROM_MEM`);
  - the exception type codes (`EXC_INT`, `EXC_SYSCALL`, `EXC_INVALID`, `EXC_OV`, `EXC_TRAP`, `EXC_ERET`);
  - the FSM state encoding.
- One sub-module, `stall_watchdog` (counter, threshold compare, sticky flag). Everything else stays in `pipe_ctrl`.

## Test plan
- Priority: `stallreq_from_id`=1 and `stallreq_from_mem`=1, no exception → `stall`=6'b011111. Drop mem → 6'b000111 next cycle.
- Syscall: `excepttype_i`=32'h8 for one cycle → `flush`=1, `stall`=0, `new_pc`=32'h20 that cycle. The next cycle has `flush`=0, `new_pc` still 32'h20, state REDIRECT.
- Eret with simultaneous mem stall: `excepttype_i`=32'he, `cp0_epc_i`=32'h0000_0104, `stallreq_from_mem`=1 → `flush`=1, `stall`=0, `new_pc`=32'h104.
- Dropped second exception: `excepttype_i`=32'h1 held for 2 cycles → `flush` is 1 then 0. It is 1 again on cycle 3 if still held.
- Watchdog: with `STALL_TIMEOUT`=4, hold `stallreq_from_ex` for 4 cycles → `stall_timeout` rises after the 4th stalled edge and stays 1 after the request drops.
- Reset mid-REDIRECT: drive `rst`=0 the cycle after a flush → all outputs 0, state RUN. With `PIPE_CTRL_PERF_EN`, `perf_flush_count`=0.
